// File: rtl/sevenseg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_scan
//  Purpose  : Time-multiplexed scan controller for a 4-digit, common-anode
//             7-segment display. A prescaler divides the clock into digit
//             slots. Each slot begins with GUARD blank cycles so that the
//             previous digit's segments do not ghost onto the next one. New
//             values are double-buffered and take effect only at a frame
//             boundary, so a frame never shows a mix of old and new digits.
//  Ports    : clk       - system clock
//             rst_n     - synchronous active-low reset
//             value_i   - four hex nibbles, [3:0] is digit 0 (rightmost)
//             load_i    - one-cycle strobe capturing value_i / dp_i
//             dp_i      - decimal-point enables, active-high, per digit
//             blank_i   - forces every anode off while high
//             nibble_o  - nibble of the current digit (to hex decoder)
//             an_o      - digit anodes, active-low, one-hot-low when lit
//             dp_o      - decimal point, active-low
//             frame_o   - one-cycle pulse at the end of each 4-digit frame
//  Options  : define SEVSEG_LZB_EN to enable leading-zero blanking
//  Revision : 1.0 - initial release
// ============================================================================
module sevenseg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_i,
  input  logic        load_i,
  input  logic [3:0]  dp_i,
  input  logic        blank_i,
  output logic [3:0]  nibble_o,
  output logic [3:0]  an_o,
  output logic        dp_o,
  output logic        frame_o
);

  localparam int             PW           = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]  c_PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]  c_GUARD      = PW'(GUARD);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_digit;
  logic [15:0]   r_disp;
  logic [3:0]    r_dp;
  logic [15:0]   r_pend;
  logic [3:0]    r_pend_dp;
  logic          r_pend_valid;

  logic          w_slot_end;
  logic          w_frame_end;
  logic          w_active;
  logic          w_digit_en;
  logic          w_lit;
  logic [3:0]    w_nibble;
  logic          w_dp_bit;
  logic [3:0]    w_an;

  assign w_slot_end  = (r_presc == c_PRESC_LAST);
  assign w_frame_end = w_slot_end && (r_digit == 2'd3);
  assign w_active    = (r_presc >= c_GUARD);
  assign w_nibble    = r_disp[{r_digit, 2'b00} +: 4];
  assign w_dp_bit    = r_dp[r_digit];

`ifdef SEVSEG_LZB_EN
  // A digit above position 0 is suppressed when it and every more
  // significant nibble are zero, unless its decimal point is requested.
  logic w_upper_zero;
  assign w_upper_zero = ((r_disp >> {r_digit, 2'b00}) == 16'h0000);
  assign w_digit_en   = (r_digit == 2'd0) || !w_upper_zero || w_dp_bit;
`else
  assign w_digit_en   = 1'b1;
`endif

  // blank_i only gates the anodes; the scan keeps running underneath.
  assign w_lit = w_active && w_digit_en && !blank_i;
  assign w_an  = w_lit ? ~(4'b0001 << r_digit) : 4'b1111;

  // Prescaler and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_digit <= 2'd0;
    end else if (w_slot_end) begin
      r_presc <= '0;
      r_digit <= r_digit + 2'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Double-buffered display data. A load landing exactly on the frame
  // boundary bypasses the pending buffer so it is not delayed a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp       <= 16'h0000;
      r_dp         <= 4'h0;
      r_pend       <= 16'h0000;
      r_pend_dp    <= 4'h0;
      r_pend_valid <= 1'b0;
    end else begin
      if (load_i) begin
        r_pend    <= value_i;
        r_pend_dp <= dp_i;
      end
      if (w_frame_end) begin
        r_pend_valid <= 1'b0;
        if (load_i) begin
          r_disp <= value_i;
          r_dp   <= dp_i;
        end else if (r_pend_valid) begin
          r_disp <= r_pend;
          r_dp   <= r_pend_dp;
        end
      end else if (load_i) begin
        r_pend_valid <= 1'b1;
      end
    end
  end

  // Registered outputs: one clock behind the scan state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_o     <= 4'b1111;
      dp_o     <= 1'b1;
      nibble_o <= 4'h0;
      frame_o  <= 1'b0;
    end else begin
      an_o     <= w_an;
      dp_o     <= w_lit ? ~w_dp_bit : 1'b1;
      nibble_o <= w_nibble;
      frame_o  <= w_frame_end;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sevenseg_scan
//  Purpose  : Self-checking bench for sevenseg_scan (REFRESH_DIV=8, GUARD=2).
//             A frame-level reference model predicts every output cycle;
//             directed table entries and sequences cover loading, anti-tear,
//             boundary loads, blanking, mid-frame reset and leading-zero
//             blanking (when SEVSEG_LZB_EN is defined).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sevenseg_scan;

  localparam int RD = 8;
  localparam int GD = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value_i;
  logic        load_i;
  logic [3:0]  dp_i;
  logic        blank_i;
  logic [3:0]  nibble_o;
  logic [3:0]  an_o;
  logic        dp_o;
  logic        frame_o;

  sevenseg_scan #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value_i  (value_i),
    .load_i   (load_i),
    .dp_i     (dp_i),
    .blank_i  (blank_i),
    .nibble_o (nibble_o),
    .an_o     (an_o),
    .dp_o     (dp_o),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  int last_frame = -1;

  // Reference model: position within the frame plus the shown and next data.
  int          m_t = 0;
  logic [15:0] m_disp = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic [15:0] m_next = 16'h0;
  logic [3:0]  m_next_dp = 4'h0;
  bit          m_has_next = 0;

  // Per-frame observations taken from the DUT.
  logic [3:0] obs_lit;
  logic [3:0] obs_nib [4];
  logic [3:0] obs_dp;
  bit         watch1 = 0;
  bit         seen1 = 0;
  int         blank_viol = 0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [15:0] exp_nibs;   // {digit3, digit2, digit1, digit0}
    logic [3:0]  exp_dpo;    // dp_o level seen in each digit's lit slot
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_obs();
    obs_lit = 4'h0;
    obs_dp  = 4'hx;
    for (int k = 0; k < 4; k++) obs_nib[k] = 4'hx;
  endtask

  task automatic cyc(input bit rn, input bit ld, input logic [15:0] v,
                     input logic [3:0] d, input bit bl);
    int dg;
    int ps;
    bit lit;
    logic [3:0] e_an;
    logic [3:0] e_nib;
    logic e_dp;
    logic e_fr;
    @(negedge clk);
    rst_n = rn; load_i = ld; value_i = v; dp_i = d; blank_i = bl;
    if (!rn) begin
      e_an = 4'hF; e_dp = 1'b1; e_nib = 4'h0; e_fr = 1'b0;
      m_t = 0; m_disp = 16'h0; m_dp = 4'h0; m_has_next = 0;
      last_frame = -1;
    end else begin
      ps  = m_t % RD;
      dg  = m_t / RD;
      lit = (ps >= GD) && !bl;
`ifdef SEVSEG_LZB_EN
      if (dg > 0 && (m_disp >> (4 * dg)) == 16'h0 && m_dp[dg] == 1'b0) lit = 0;
`endif
      e_an = 4'hF;
      if (lit) e_an[dg] = 1'b0;
      e_nib = m_disp[4*dg +: 4];
      e_dp  = lit ? ~m_dp[dg] : 1'b1;
      e_fr  = (m_t == FRAME - 1);
      // The last load seen up to and including the frame's final cycle
      // becomes the next frame's content.
      if (ld) begin m_next = v; m_next_dp = d; m_has_next = 1; end
      if (m_t == FRAME - 1 && m_has_next) begin
        m_disp = m_next; m_dp = m_next_dp; m_has_next = 0;
      end
      m_t = (m_t + 1) % FRAME;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    checks++;
    if ({an_o, dp_o, nibble_o, frame_o} !== {e_an, e_dp, e_nib, e_fr}) begin
      errors++;
      $display("FAIL out cyc %0d: an=%b dp=%b nib=%h fr=%b expected an=%b dp=%b nib=%h fr=%b",
               cyc_n, an_o, dp_o, nibble_o, frame_o, e_an, e_dp, e_nib, e_fr);
    end
    if (frame_o === 1'b1) begin
      if (last_frame >= 0) check("frame_gap", cyc_n - last_frame, FRAME);
      last_frame = cyc_n;
    end
    if (watch1 && nibble_o === 4'h1) seen1 = 1;
    if (rn && bl && (an_o !== 4'hF || dp_o !== 1'b1)) blank_viol++;
    for (int k = 0; k < 4; k++) begin
      if (an_o[k] === 1'b0) begin
        obs_lit[k] = 1'b1;
        obs_nib[k] = nibble_o;
        obs_dp[k]  = dp_o;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 16'h0, 4'h0, 0);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    cyc(1, 1, v, d, 0);
  endtask

  // Advance to the start of a frame, then observe one whole frame.
  task automatic observe_frame();
    while (m_t != 0) idle(1);
    clr_obs();
    idle(FRAME);
  endtask

  function automatic logic [15:0] obs_nibs();
    return {obs_nib[3], obs_nib[2], obs_nib[1], obs_nib[0]};
  endfunction

  initial begin
    vecs[0] = '{value: 16'hA3C5, dp: 4'b0100, exp_nibs: {4'hA, 4'h3, 4'hC, 4'h5}, exp_dpo: 4'b1011};
    vecs[1] = '{value: 16'h1234, dp: 4'b1001, exp_nibs: {4'h1, 4'h2, 4'h3, 4'h4}, exp_dpo: 4'b0110};
    vecs[2] = '{value: 16'h8001, dp: 4'b0010, exp_nibs: {4'h8, 4'h0, 4'h0, 4'h1}, exp_dpo: 4'b1101};
    vecs[3] = '{value: 16'hFFFF, dp: 4'b1111, exp_nibs: {4'hF, 4'hF, 4'hF, 4'hF}, exp_dpo: 4'b0000};

    rst_n = 1'b0; load_i = 1'b0; value_i = 16'h0; dp_i = 4'h0; blank_i = 1'b0;
    clr_obs();

    // Reset values.
    for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0, 4'h0, 0);
    check("reset_an", an_o, 4'hF);
    check("reset_dp", dp_o, 1'b1);

    // Idle scan after reset: every digit lights and shows 0.
    observe_frame();
    check("scan_lit", obs_lit, 4'hF);
    check("scan_nib", obs_nibs(), 16'h0000);
    idle(40);

    // Table-driven loads, each observed in the following frame.
    for (int i = 0; i < 4; i++) begin
      idle(3 + 5 * i);
      load(vecs[i].value, vecs[i].dp);
      observe_frame();
      check("tbl_lit", obs_lit, 4'hF);
      check("tbl_nib", obs_nibs(), vecs[i].exp_nibs);
      check("tbl_dp", obs_dp, vecs[i].exp_dpo);
    end

    // Anti-tear: two loads in one frame, only the last one ever appears.
    while (m_t != RD + 3) idle(1);
    watch1 = 1; seen1 = 0;
    load(16'h1111, 4'h0);
    while (m_t != 2 * RD + 3) idle(1);
    load(16'h2222, 4'h0);
    observe_frame();
    watch1 = 0;
    check("tear_nib", obs_nibs(), 16'h2222);
    check("tear_seen1", seen1, 1'b0);

    // Load coinciding with the frame boundary goes straight to the display.
    while (m_t != FRAME - 1) idle(1);
    load(16'h00F0, 4'h0);
    clr_obs();
    idle(FRAME);
    check("bnd_d0", obs_nib[0], 4'h0);
    check("bnd_d1", obs_nib[1], 4'hF);

    // Blank for 40 cycles: nothing lit, scan continues.
    blank_viol = 0;
    for (int i = 0; i < 40; i++) cyc(1, 0, 16'h0, 4'h0, 1);
    check("blank_viol", blank_viol, 0);
    idle(40);

    // Mid-frame reset discards a pending load.
    while (m_t != 5) idle(1);
    load(16'h7777, 4'hF);
    idle(4);
    cyc(0, 0, 16'h0, 4'h0, 0);
    cyc(0, 0, 16'h0, 4'h0, 0);
    observe_frame();
    check("rst_nib", obs_nibs(), 16'h0000);
    check("rst_lit", obs_lit, 4'hF);

    // Leading-zero blanking.
    load(16'h0042, 4'h0);
    observe_frame();
`ifdef SEVSEG_LZB_EN
    check("lzb42_lit", obs_lit, 4'b0011);
    load(16'h0000, 4'h0);
    observe_frame();
    check("lzb0_lit", obs_lit, 4'b0001);
    check("lzb0_nib", obs_nib[0], 4'h0);
`else
    check("nolzb_lit", obs_lit, 4'hF);
    check("nolzb_nib", obs_nibs(), 16'h0042);
`endif

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 9) == 0),
          16'($urandom),
          4'($urandom),
          ($urandom_range(0, 7) == 0));
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sevenseg_scan.md
SEVENSEG_SCAN -- requirements
Module: sevenseg_scan

Interface
REQ-001 The module SHALL have parameter REFRESH_DIV, default 100000: clock cycles per digit slot, legal range 2..2^20.
REQ-002 The module SHALL have parameter GUARD, default 16: anti-ghosting blank cycles at the start of each slot, legal range 0..REFRESH_DIV-1.
REQ-003 The module SHALL have port clk  input  1  system clock; the module uses this one clock.
REQ-004 The module SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The module SHALL have port value_i  input  16  four hex nibbles to display; [3:0] is digit 0 (rightmost).
REQ-006 The module SHALL have port load_i  input  1  single-cycle strobe that captures value_i and dp_i.
REQ-007 The module SHALL have port dp_i  input  4  decimal-point enables, active-high, one per digit.
REQ-008 The module SHALL have port blank_i  input  1  level input that forces all anodes off while high.
REQ-009 The module SHALL have port nibble_o  output  4  current digit nibble, feeding the hex-to-segment decoder d3..d0.
REQ-010 The module SHALL have port an_o  output  4  digit anodes, active-low, one-hot-low when lit.
REQ-011 The module SHALL have port dp_o  output  1  decimal point, active-low.
REQ-012 The module SHALL have port frame_o  output  1  one-cycle pulse marking the end of each 4-digit frame.

Function
REQ-013 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; at the terminal count, the digit index SHALL advance 0->1->2->3->0.
REQ-014 The digit slot SHALL be active when the prescaler is >= GUARD; during the active slot, an_o SHALL drive only bit[digit] low; otherwise an_o SHALL be 4'b1111.
REQ-015 nibble_o SHALL equal display_reg[4*digit+3 : 4*digit] in all cycles, including guard cycles.
REQ-016 dp_o SHALL be ~dp_reg[digit] during the active slot and 1 otherwise.
REQ-017 All outputs SHALL be registered and SHALL reflect the prescaler/digit state of the previous cycle, giving a latency of one clock.
REQ-018 load_i SHALL write value_i and dp_i into a pending register and set pending_valid.
REQ-019 If load_i strobes more than once within a frame, the last strobe SHALL win.
REQ-020 The frame boundary SHALL be defined as the cycle with prescaler == REFRESH_DIV-1 and digit == 3.
REQ-021 At the frame boundary, if pending_valid is set, pending SHALL copy into display_reg/dp_reg and pending_valid SHALL clear; this prevents tearing within a frame.
REQ-022 If load_i coincides with the frame boundary, value_i and dp_i SHALL go directly into display_reg/dp_reg, and pending_valid SHALL end at 0.
REQ-023 frame_o SHALL pulse high for one cycle, aligned with the an_o transition from digit 3 to digit 0.
REQ-024 blank_i SHALL force an_o to 4'b1111 and dp_o to 1 (with one clock of latency) without stalling the prescaler, the digit index or frame_o.

Reset
REQ-025 When rst_n is sampled low, the following SHALL be set: prescaler=0, digit=0, display_reg=0, dp_reg=0, pending=0, pending_valid=0.
REQ-026 When rst_n is sampled low, the outputs SHALL be set to an_o=4'b1111, dp_o=1, nibble_o=0, frame_o=0.
REQ-027 A reset asserted mid-frame SHALL discard any pending load, and counting SHALL restart from digit 0 on the first cycle with rst_n high.

Configuration
REQ-028 With macro SEVSEG_LZB_EN defined, leading-zero blanking SHALL apply: digit k (k>0) is treated as inactive when all nibbles at index >= k in display_reg are 0 and dp_reg[k] is 0.
REQ-029 With SEVSEG_LZB_EN defined, digit 0 SHALL always be displayed.
REQ-030 With SEVSEG_LZB_EN defined, slot timing and frame_o SHALL be unchanged.
REQ-031 Without SEVSEG_LZB_EN, all four digits SHALL always be displayed and no blanking logic SHALL be present.

Verification (REFRESH_DIV=8, GUARD=2)
REQ-032 Reset and scan: release rst_n and hold load_i=0 -> an_o SHALL cycle 1110,1101,1011,0111 with each lit for 6 cycles and preceded by 2 cycles of 1111, frame_o SHALL pulse every 32 cycles, and nibble_o SHALL be 0.
REQ-033 Load: load_i with value_i=16'hA3C5 and dp_i=4'b0100 -> from the next frame, nibble_o SHALL be 5,C,3,A for digits 0..3, and dp_o SHALL be 0 only in digit 2's active slot.
REQ-034 Anti-tear: load 16'h1111 during digit 1, then 16'h2222 during digit 2 -> the current frame SHALL show the old value and the next frame SHALL show 2 on all digits; 1111 SHALL never be displayed.
REQ-035 Boundary load: load_i=1 with 16'h00F0 exactly on the frame boundary -> the immediately following digit-0 slot SHALL show nibble 0 and digit 1 SHALL show F.
REQ-036 Blank: hold blank_i=1 for 40 cycles -> an_o SHALL be 1111 and dp_o SHALL be 1 throughout, and frame_o pulses SHALL keep 32-cycle spacing.
REQ-037 LZB (macro defined): display 16'h0042 -> an_o[3:2] SHALL never go low, and digits 0 and 1 SHALL light; display 16'h0000 -> only digit 0 SHALL light and show 0.
